// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU frame sequencer.
//   state_t      : sequencer states, 3-bit, IDLE=0 .. WAIT_TX=5
//   OP_*         : the eight legal 6-bit ALU opcodes
//   is_legal_op  : 1 when a 6-bit opcode is one of the OP_* constants
package uart_alu_pkg;

   localparam int OP_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GET_B   = 3'd1,
      ST_GET_OP  = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5
   } state_t;

   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_legal_op = 1'b1;
         default:                        is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_alu_seq_frame_timer.sv
// Inter-byte timeout counter.
//   i_clk, i_rst : clock, synchronous active-low reset
//   clr          : clear count to zero (has priority over en)
//   en           : count one cycle
//   expired      : count has reached TIMEOUT_CYC-1 (saturates there)
module frame_timer #(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] count;

   assign expired = (count == LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && !expired)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/uart_alu_seq.sv
// Frame sequencer between UART RX, a combinational ALU and UART TX.
// Collects A, B, OP bytes, validates OP, drives registered ALU operands,
// captures the result and sends it back through the TX start/done handshake.
//   i_clk, i_rst            : clock, synchronous active-low reset
//   i_rx_data, i_rx_done    : received byte and its 1-cycle strobe
//   o_a, o_b, o_op          : registered ALU operands / opcode
//   i_alu_result            : combinational ALU result
//   o_tx_data, o_tx_start   : result byte and 1-cycle TX start pulse
//   i_tx_done               : 1-cycle TX finished pulse
//   o_busy                  : state != IDLE
//   o_err_timeout/op/overrun: 1-cycle error pulses
module uart_alu_seq
   import uart_alu_pkg::*;
#(
   parameter int NB_DATA     = 8,
   parameter int NB_OPERADOR = 6,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NB_DATA-1:0]     i_rx_data,
   input  logic                   i_rx_done,
   output logic [NB_DATA-1:0]     o_a,
   output logic [NB_DATA-1:0]     o_b,
   output logic [NB_OPERADOR-1:0] o_op,
   input  logic [NB_DATA-1:0]     i_alu_result,
   output logic [NB_DATA-1:0]     o_tx_data,
   output logic                   o_tx_start,
   input  logic                   i_tx_done,
   output logic                   o_busy,
   output logic                   o_err_timeout,
   output logic                   o_err_op,
   output logic                   o_err_overrun
);

   state_t                   state, state_nx;
   logic [NB_DATA-1:0]       a_nx, b_nx, tx_data_nx;
   logic [NB_OPERADOR-1:0]   op_nx, op_field;
   logic                     start_nx, err_to_nx, err_op_nx, err_ov_nx;
   logic                     tmr_clr, tmr_en, tmr_expired;

   assign op_field = i_rx_data[NB_OPERADOR-1:0];
   assign o_busy   = (state != ST_IDLE);

   frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state         <= ST_IDLE;
         o_a           <= '0;
         o_b           <= '0;
         o_op          <= '0;
         o_tx_data     <= '0;
         o_tx_start    <= 1'b0;
         o_err_timeout <= 1'b0;
         o_err_op      <= 1'b0;
         o_err_overrun <= 1'b0;
      end else begin
         state         <= state_nx;
         o_a           <= a_nx;
         o_b           <= b_nx;
         o_op          <= op_nx;
         o_tx_data     <= tx_data_nx;
         o_tx_start    <= start_nx;
         o_err_timeout <= err_to_nx;
         o_err_op      <= err_op_nx;
         o_err_overrun <= err_ov_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      a_nx       = o_a;
      b_nx       = o_b;
      op_nx      = o_op;
      tx_data_nx = o_tx_data;
      start_nx   = 1'b0;
      err_to_nx  = 1'b0;
      err_op_nx  = 1'b0;
      err_ov_nx  = 1'b0;
      // Timer only runs while a frame is partially received; every accepted
      // byte restarts it, and leaving these states clears it.
      tmr_en     = (state == ST_GET_B) || (state == ST_GET_OP);
      tmr_clr    = !tmr_en || i_rx_done;

      case (state)
         ST_IDLE: begin
            if (i_rx_done) begin
               a_nx     = i_rx_data;
               state_nx = ST_GET_B;
            end
         end
         ST_GET_B: begin
            // A byte arriving on the expiry cycle wins over the abort.
            if (i_rx_done) begin
               b_nx     = i_rx_data;
               state_nx = ST_GET_OP;
            end else if (tmr_expired) begin
               err_to_nx = 1'b1;
               state_nx  = ST_IDLE;
            end
         end
         ST_GET_OP: begin
            if (i_rx_done) begin
               if (is_legal_op(op_field)) begin
                  op_nx    = op_field;
                  state_nx = ST_EXEC;
               end else begin
                  err_op_nx = 1'b1;
                  state_nx  = ST_IDLE;
               end
            end else if (tmr_expired) begin
               err_to_nx = 1'b1;
               state_nx  = ST_IDLE;
            end
         end
         ST_EXEC: begin
            tx_data_nx = i_alu_result;
            err_ov_nx  = i_rx_done;
            state_nx   = ST_SEND;
         end
         ST_SEND: begin
            start_nx  = 1'b1;
            err_ov_nx = i_rx_done;
            state_nx  = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            err_ov_nx = i_rx_done;
            if (i_tx_done)
               state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_alu_seq.sv
module tb_uart_alu_seq;

   localparam int TO = 16;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [7:0] i_rx_data;
   logic       i_rx_done;
   logic [7:0] o_a, o_b;
   logic [5:0] o_op;
   logic [7:0] i_alu_result;
   logic [7:0] o_tx_data;
   logic       o_tx_start, i_tx_done, o_busy;
   logic       o_err_timeout, o_err_op, o_err_overrun;

   int n_cmp = 0, n_bad = 0;
   int n_start = 0, n_eto = 0, n_eop = 0, n_eov = 0;
   int exp_start = 0, exp_eto = 0, exp_eop = 0, exp_eov = 0;
   logic [5:0] last_op = '0;

   always #5 i_clk = ~i_clk;

   // Reference ALU: plain arithmetic on byte values.
   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
      int sa, r;
      sa = (a >= 128) ? int'(a) - 256 : int'(a);
      case (op)
         6'b100000: r = int'(a) + int'(b);
         6'b100010: r = int'(a) - int'(b);
         6'b100100: r = int'(a & b);
         6'b100101: r = int'(a | b);
         6'b100110: r = int'(a ^ b);
         6'b100111: r = int'(~(a | b));
         6'b000011: r = (b >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> b);
         6'b000010: r = (b >= 8) ? 0 : (int'(a) >> b);
         default:   r = 0;
      endcase
      return r[7:0];
   endfunction

   function automatic bit op_ok(input logic [5:0] op);
      logic [5:0] legal [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
      foreach (legal[i]) if (legal[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   assign i_alu_result = alu_ref(o_a, o_b, o_op);

   uart_alu_seq #(.NB_DATA(8), .NB_OPERADOR(6), .TIMEOUT_CYC(TO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
      .o_a(o_a), .o_b(o_b), .o_op(o_op), .i_alu_result(i_alu_result),
      .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
      .o_busy(o_busy), .o_err_timeout(o_err_timeout), .o_err_op(o_err_op),
      .o_err_overrun(o_err_overrun)
   );

   always @(negedge i_clk) begin
      if (o_tx_start)    n_start++;
      if (o_err_timeout) n_eto++;
      if (o_err_op)      n_eop++;
      if (o_err_overrun) n_eov++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called just after a negedge; byte is sampled on the next posedge.
   task automatic send_byte(input logic [7:0] d);
      i_rx_data = d;
      i_rx_done = 1'b1;
      @(negedge i_clk);
      i_rx_done = 1'b0;
      i_rx_data = $urandom();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic pulse_tx_done();
      i_tx_done = 1'b1;
      @(negedge i_clk);
      i_tx_done = 1'b0;
   endtask

   task automatic wait_start(output int k);
      k = 0;
      while (!o_tx_start && k < 20) begin
         @(negedge i_clk);
         k++;
      end
   endtask

   // Everything after the OP byte has been accepted.
   task automatic finish_frame(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] opb, input bit ovr);
      logic [5:0] op6;
      logic [7:0] res;
      int k;
      op6 = opb[5:0];
      if (!op_ok(op6)) begin
         exp_eop++;
         check_eq("err_op_pulse", o_err_op, 1);
         check_eq("busy_after_bad_op", o_busy, 0);
         check_eq("op_unchanged", o_op, last_op);
         return;
      end
      last_op = op6;
      res = alu_ref(a, b, op6);
      check_eq("o_a", o_a, a);
      check_eq("o_b", o_b, b);
      check_eq("o_op", o_op, op6);
      wait_start(k);
      check_eq("start_latency", k, 2);
      check_eq("tx_data", o_tx_data, res);
      exp_start++;
      @(negedge i_clk);
      check_eq("start_one_cycle", o_tx_start, 0);
      idle($urandom_range(0, 3));
      if (ovr) begin
         send_byte($urandom());
         exp_eov++;
         check_eq("err_overrun", o_err_overrun, 1);
         check_eq("tx_data_kept", o_tx_data, res);
         check_eq("busy_in_wait_tx", o_busy, 1);
      end
      pulse_tx_done();
      check_eq("busy_after_tx_done", o_busy, 0);
   endtask

   task automatic do_frame(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] opb, input bit ovr);
      send_byte(a);
      idle($urandom_range(0, 4));
      send_byte(b);
      idle($urandom_range(0, 4));
      send_byte(opb);
      finish_frame(a, b, opb, ovr);
   endtask

   task automatic do_reset();
      i_rst = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b1;
      last_op = '0;
      check_eq("rst_o_a", o_a, 0);
      check_eq("rst_o_b", o_b, 0);
      check_eq("rst_o_op", o_op, 0);
      check_eq("rst_tx_data", o_tx_data, 0);
      check_eq("rst_busy", o_busy, 0);
      check_eq("rst_start", o_tx_start, 0);
   endtask

   initial begin
      logic [5:0] legal_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
      logic [7:0] a, b, opb;
      int k;

      i_rst = 1'b0; i_rx_done = 1'b0; i_rx_data = '0; i_tx_done = 1'b0;
      idle(3);
      check_eq("reset_o_a", o_a, 0);
      check_eq("reset_tx_data", o_tx_data, 0);
      check_eq("reset_busy", o_busy, 0);
      i_rst = 1'b1;
      @(negedge i_clk);

      // Directed: ADD, then illegal opcode
      do_frame(8'h05, 8'h03, 8'h20, 1'b0);
      do_frame(8'h0F, 8'h01, 8'h3F, 1'b0);

      // Timeout after a lone first byte, then a normal SUB frame
      send_byte(8'hAA);
      k = 0;
      while (!o_err_timeout && k < 40) begin
         @(negedge i_clk);
         k++;
      end
      exp_eto++;
      check_eq("timeout_cycles", k, TO);
      check_eq("busy_after_timeout", o_busy, 0);
      @(negedge i_clk);
      check_eq("timeout_one_cycle", o_err_timeout, 0);
      do_frame(8'h01, 8'h02, 8'h22, 1'b0);

      // Bytes arriving exactly on the expiry cycle are accepted
      send_byte(8'h81);
      idle(TO - 1);
      send_byte(8'h02);
      check_eq("edge_b_busy", o_busy, 1);
      idle(TO - 1);
      send_byte(8'h03);
      check_eq("edge_op_no_timeout", o_err_timeout, 0);
      finish_frame(8'h81, 8'h02, 8'h03, 1'b0);

      // Overrun during WAIT_TX
      do_frame(8'h37, 8'h11, 8'h26, 1'b1);

      // Randomized frames
      for (int i = 0; i < 30; i++) begin
         a = $urandom();
         b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom());
         if ($urandom_range(0, 4) == 0) opb = $urandom();
         else opb = {2'($urandom()), legal_tab[$urandom_range(0, 7)]};
         do_frame(a, b, opb, $urandom_range(0, 3) == 0);
         idle($urandom_range(0, 2));
      end

      // Reset in GET_OP
      send_byte(8'h44);
      send_byte(8'h55);
      do_reset();
      idle(5);
      check_eq("no_start_after_rst1", n_start, exp_start);

      // Reset in WAIT_TX
      send_byte(8'h09);
      send_byte(8'h07);
      send_byte(8'h24);
      wait_start(k);
      check_eq("pre_rst_start_latency", k, 2);
      exp_start++;
      @(negedge i_clk);
      do_reset();
      idle(3);
      pulse_tx_done();
      check_eq("busy_after_stray_done", o_busy, 0);
      idle(5);
      check_eq("no_start_after_rst2", n_start, exp_start);

      // Post-reset frame still works
      do_frame(8'hF0, 8'h04, 8'h03, 1'b0);

      check_eq("total_starts", n_start, exp_start);
      check_eq("total_err_timeout", n_eto, exp_eto);
      check_eq("total_err_op", n_eop, exp_eop);
      check_eq("total_err_overrun", n_eov, exp_eov);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
